// File: rtl/i2c_target_responder.sv
// I2C target with a fixed 7-bit address. SCL/SDA are oversampled by the system clock and
// bus events are reported as single-cycle pulses. Written bytes are ACKed, read bytes are fetched on request.
module i2c_target_responder #(
    parameter int unsigned                I2C_ADDR_WIDTH = 7,
    parameter int unsigned                I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0]  TARGET_ADDR    = 7'h69
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic [I2C_ADDR_WIDTH-1:0] addr_o,
    output logic                      rw_o,
    output logic                      wr_valid_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      rd_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    output logic                      rd_nack_o
);

    localparam int unsigned           CNT_W    = $clog2(I2C_DATA_WIDTH);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(I2C_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK, WR_DATA, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [I2C_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [I2C_DATA_WIDTH-1:0] rx_byte;
    logic [1:0]                scl_s, sda_s;
    logic                      scl_d, sda_d;
    logic                      scl_rise, scl_fall, start_det, stop_det;
    logic                      sda_n, start_n, stop_n, wr_valid_n, rd_req_n, rd_nack_n, rw_n;
    logic [I2C_ADDR_WIDTH-1:0] addr_n;
    logic [I2C_DATA_WIDTH-1:0] wr_data_n;

    assign scl_o = 1'b1;

    // Synchronizers reset to the idle-bus level so leaving reset cannot fake a START/STOP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values, so the chain shifts by one stage per clock.
            scl_s <= {scl_s[0], scl_i};
            sda_s <= {sda_s[0], sda_i};
            scl_d <= scl_s[1];
            sda_d <= sda_s[1];
        end
    end

    assign scl_rise  =  scl_s[1] & ~scl_d;
    assign scl_fall  = ~scl_s[1] &  scl_d;
    assign start_det =  scl_s[1] &  scl_d & sda_d & ~sda_s[1];
    assign stop_det  =  scl_s[1] &  scl_d & ~sda_d & sda_s[1];

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and infers a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = rd_req_o ? rd_data_i : shift_q;
        rx_byte    = {shift_q[I2C_DATA_WIDTH-2:0], sda_s[1]};
        sda_n      = sda_o;
        addr_n     = addr_o;
        rw_n       = rw_o;
        wr_data_n  = wr_data_o;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        wr_valid_n = 1'b0;
        rd_req_n   = 1'b0;
        rd_nack_n  = 1'b0;

        if (stop_det) begin
            stop_n  = 1'b1;
            sda_n   = 1'b1;
            state_d = IDLE;
        end else if (start_det) begin
            start_n   = 1'b1;
            sda_n     = 1'b1;
            bit_cnt_d = '0;
            state_d   = ADDR;
        end else begin
            unique case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        addr_n  = rx_byte[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH];
                        rw_n    = rx_byte[0];
                        state_d = (rx_byte[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == TARGET_ADDR) ? ACK : IGNORE;
                    end
                end
                // Shared ACK slot for the address byte and every written byte; rw_o picks the follow-on phase.
                ACK: begin
                    if (scl_fall) begin
                        sda_n = 1'b0;
                    end else if (scl_rise) begin
                        bit_cnt_d = '0;
                        if (rw_o) begin
                            rd_req_n = 1'b1;
                            state_d  = RD_DATA;
                        end else begin
                            state_d  = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_fall) begin
                        sda_n = 1'b1;
                    end else if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            wr_data_n  = rx_byte;
                            wr_valid_n = 1'b1;
                            state_d    = ACK;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        sda_n   = shift_q[I2C_DATA_WIDTH-1];
                        shift_d = {shift_q[I2C_DATA_WIDTH-2:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) state_d = RD_ACK;
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        sda_n = 1'b1;
                    end else if (scl_rise) begin
                        bit_cnt_d = '0;
                        if (!sda_s[1]) begin
                            rd_req_n = 1'b1;
                            state_d  = RD_DATA;
                        end else begin
                            rd_nack_n = 1'b1;
                            state_d   = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sda_o      <= 1'b1;
            addr_o     <= '0;
            rw_o       <= 1'b0;
            wr_data_o  <= '0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
            rd_nack_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_o      <= sda_n;
            addr_o     <= addr_n;
            rw_o       <= rw_n;
            wr_data_o  <= wr_data_n;
            start_o    <= start_n;
            stop_o     <= stop_n;
            wr_valid_o <= wr_valid_n;
            rd_req_o   <= rd_req_n;
            rd_nack_o  <= rd_nack_n;
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bit-banged I2C controller model driving i2c_target_responder; expected pulses are queued
// by the stimulus and popped by a monitor whenever the target raises an event pulse.
`timescale 1ns/1ps
module tb_i2c_target_responder;

    localparam int Q_NS = 100;

    typedef enum logic [2:0] {EV_START, EV_STOP, EV_WR, EV_RDREQ, EV_NACK} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_bus, sda_bus;
    logic       scl_o, sda_o, start_o, stop_o, rw_o, wr_valid_o, rd_req_o, rd_nack_o;
    logic [6:0] addr_o;
    logic [7:0] wr_data_o, rd_data_i;
    logic [7:0] rd_tbl [4] = '{8'hA5, 8'h3C, 8'h96, 8'h00};
    int         rd_idx = 0;
    int         total = 0;
    int         bad = 0;
    ev_t        exp_q[$];

    assign scl_bus   = scl_m & scl_o;
    assign sda_bus   = sda_m & sda_o;
    assign rd_data_i = rd_tbl[rd_idx[1:0]];

    always #5 clk = ~clk;

    i2c_target_responder dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .scl_i      (scl_bus),
        .sda_i      (sda_bus),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .addr_o     (addr_o),
        .rw_o       (rw_o),
        .wr_valid_o (wr_valid_o),
        .wr_data_o  (wr_data_o),
        .rd_req_o   (rd_req_o),
        .rd_data_i  (rd_data_i),
        .rd_nack_o  (rd_nack_o)
    );

    always @(posedge clk) if (rd_req_o) rd_idx <= rd_idx + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic void expect_ev(input ev_kind_t k, input logic [7:0] d);
        exp_q.push_back('{kind: k, data: d});
    endfunction

    task automatic see_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind=%0d data=%02h, required no event", k, d);
        end else begin
            e = exp_q.pop_front();
            check("event {kind,data}", 32'({k, d}), 32'({e.kind, e.data}));
        end
    endtask

    // Monitor: any pulse from the target is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (start_o)    see_ev(EV_START, 8'h00);
        if (stop_o)     see_ev(EV_STOP, 8'h00);
        if (wr_valid_o) see_ev(EV_WR, wr_data_o);
        if (rd_req_o)   see_ev(EV_RDREQ, 8'h00);
        if (rd_nack_o)  see_ev(EV_NACK, 8'h00);
    end

    task automatic i2c_start();
        sda_m = 1'b1; #(Q_NS);
        scl_m = 1'b1; #(Q_NS);
        sda_m = 1'b0; #(Q_NS);
        scl_m = 1'b0; #(Q_NS);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q_NS);
        scl_m = 1'b1; #(Q_NS);
        sda_m = 1'b1; #(Q_NS);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b;    #(Q_NS);
        scl_m = 1'b1; #(Q_NS);
        r = sda_bus;  #(Q_NS);
        scl_m = 1'b0; #(Q_NS);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, r);
            d = {d[6:0], r};
        end
        clock_bit(nack, r);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack, r;
        logic [7:0] d;

        rst_n = 1'b0;
        #(50);
        check("reset sda_o", sda_o, 1);
        check("reset scl_o", scl_o, 1);
        check("reset addr_o", addr_o, 0);
        check("reset rw_o", rw_o, 0);
        check("reset wr_data_o", wr_data_o, 0);
        check("reset pulses", {start_o, stop_o, wr_valid_o, rd_req_o, rd_nack_o}, 0);
        rst_n = 1'b1;
        #(Q_NS);

        // Write 0x69 + 32 bytes 0..31
        expect_ev(EV_START, 8'h00);
        i2c_start();
        write_byte(8'hD2, ack);
        check("w32 addr ack", ack, 0);
        for (int i = 0; i < 32; i++) begin
            expect_ev(EV_WR, 8'(i));
            write_byte(8'(i), ack);
            check("w32 data ack", ack, 0);
        end
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();
        check("w32 addr_o", addr_o, 7'h69);
        check("w32 rw_o", rw_o, 0);
        check("w32 last wr_data_o", wr_data_o, 8'd31);

        // Write to a foreign address
        expect_ev(EV_START, 8'h00);
        i2c_start();
        write_byte(8'h44, ack);
        check("foreign addr nack", ack, 1);
        write_byte(8'h12, ack);
        check("foreign data nack", ack, 1);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();
        check("foreign addr_o", addr_o, 7'h22);
        check("foreign wr_data_o kept", wr_data_o, 8'd31);

        // Read two bytes: ACK the first, NACK the second
        expect_ev(EV_START, 8'h00);
        i2c_start();
        expect_ev(EV_RDREQ, 8'h00);
        write_byte(8'hD3, ack);
        check("rd addr ack", ack, 0);
        check("rd rw_o", rw_o, 1);
        expect_ev(EV_RDREQ, 8'h00);
        read_byte(1'b0, d);
        check("rd byte0", d, 8'hA5);
        expect_ev(EV_NACK, 8'h00);
        read_byte(1'b1, d);
        check("rd byte1", d, 8'h3C);
        check("rd sda released", sda_o, 1);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();

        // Write one byte, repeated START, read one byte
        expect_ev(EV_START, 8'h00);
        i2c_start();
        write_byte(8'hD2, ack);
        check("rs addr ack", ack, 0);
        expect_ev(EV_WR, 8'h55);
        write_byte(8'h55, ack);
        check("rs data ack", ack, 0);
        expect_ev(EV_START, 8'h00);
        i2c_start();
        expect_ev(EV_RDREQ, 8'h00);
        write_byte(8'hD3, ack);
        check("rs read addr ack", ack, 0);
        check("rs rw_o", rw_o, 1);
        check("rs wr_data_o", wr_data_o, 8'h55);
        expect_ev(EV_NACK, 8'h00);
        read_byte(1'b1, d);
        check("rs rd byte", d, 8'h96);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();

        // Reset while the target drives an ACK
        expect_ev(EV_START, 8'h00);
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'hD2;
            clock_bit(d[i], r);
        end
        check("ack driven before reset", sda_o, 0);
        rst_n = 1'b0;
        #1;
        check("async reset releases sda", sda_o, 1);
        sda_m = 1'b1; #(Q_NS);
        rst_n = 1'b1; #(Q_NS);
        scl_m = 1'b1; #(Q_NS);
        check("post reset addr_o", addr_o, 0);
        expect_ev(EV_START, 8'h00);
        i2c_start();
        write_byte(8'hD2, ack);
        check("post reset addr ack", ack, 0);
        expect_ev(EV_WR, 8'hAB);
        write_byte(8'hAB, ack);
        check("post reset data ack", ack, 0);
        expect_ev(EV_STOP, 8'h00);
        i2c_stop();
        #(Q_NS);
        check("post reset wr_data_o", wr_data_o, 8'hAB);
        check("expected events left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
